// File: rtl/shadow_chain_unload.sv
// Shadow-chain unloader: snapshots a parallel word on capture, then shifts it out LSB first
// while the downstream arbiter grants dump_cmd, optionally followed by an even-parity trailer.
module shadow_chain_unload #(
   parameter int CHAIN_LEN = 8,
   parameter int PARITY    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 capture,
   input  logic [CHAIN_LEN-1:0] din,
   input  logic                 dump_cmd,
   output logic                 chain_out,
   output logic                 chain_vld,
   output logic                 chain_status,
   output logic                 capture_drop
);

   localparam int CNT_W = $clog2(CHAIN_LEN + 2);
   localparam logic [CNT_W-1:0] DATA_BITS  = CNT_W'(CHAIN_LEN);
   localparam logic [CNT_W-1:0] TOTAL_BITS = CNT_W'(CHAIN_LEN + PARITY);

   typedef enum logic [1:0] {
      EMPTY,
      LOADED,
      SHIFT
   } state_t;

   state_t               state, state_nxt;
   logic [CHAIN_LEN-1:0] shift_reg, shift_nxt;
   logic [CNT_W-1:0]     cnt, cnt_nxt;
   logic                 par_acc, par_nxt;
   logic                 out_nxt, vld_nxt, status_nxt, drop_nxt;
   logic                 advance;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= EMPTY;
         shift_reg    <= '0;
         cnt          <= '0;
         par_acc      <= 1'b0;
         chain_out    <= 1'b0;
         chain_vld    <= 1'b0;
         chain_status <= 1'b1;
         capture_drop <= 1'b0;
      end else begin
         state        <= state_nxt;
         shift_reg    <= shift_nxt;
         cnt          <= cnt_nxt;
         par_acc      <= par_nxt;
         chain_out    <= out_nxt;
         chain_vld    <= vld_nxt;
         chain_status <= status_nxt;
         capture_drop <= drop_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      shift_nxt  = shift_reg;
      cnt_nxt    = cnt;
      par_nxt    = par_acc;
      out_nxt    = chain_out;
      vld_nxt    = 1'b0;
      status_nxt = chain_status;
      drop_nxt   = 1'b0;
      advance    = 1'b0;

      case (state)
         EMPTY: begin
            out_nxt    = 1'b0;
            status_nxt = 1'b1;
            if (capture) begin
               shift_nxt  = din;
               cnt_nxt    = '0;
               par_nxt    = 1'b0;
               status_nxt = 1'b0;
               state_nxt  = LOADED;
            end
         end
         LOADED: begin
            status_nxt = 1'b0;
            // A fresh capture wins over the grant; the unload starts on a later grant.
            if (capture) begin
               shift_nxt = din;
            end else if (dump_cmd) begin
               advance   = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            drop_nxt = capture;
            // cnt == TOTAL_BITS means the last bit is on the output now; retire next edge.
            if (cnt == TOTAL_BITS) begin
               state_nxt  = EMPTY;
               status_nxt = 1'b1;
               out_nxt    = 1'b0;
               cnt_nxt    = '0;
               par_nxt    = 1'b0;
            end else if (dump_cmd) begin
               advance = 1'b1;
            end
         end
         default: begin
            state_nxt = EMPTY;
         end
      endcase

      if (advance) begin
         vld_nxt = 1'b1;
         cnt_nxt = cnt + CNT_W'(1);
         if (cnt < DATA_BITS) begin
            out_nxt   = shift_reg[0];
            par_nxt   = par_acc ^ shift_reg[0];
            shift_nxt = shift_reg >> 1;
         end else begin
            out_nxt = par_acc;
         end
      end
   end

endmodule

// File: tb/tb_shadow_chain_unload.sv
// Directed bench for shadow_chain_unload: expected serial bits are queued at capture time
// and a negedge monitor pops one per chain_vld cycle.
module tb_shadow_chain_unload;

   logic       clk = 1'b0;
   logic       rst, capture, dump_cmd;
   logic [7:0] din;
   logic       chain_out, chain_vld, chain_status, capture_drop;

   logic       capture1, dump1;
   logic [0:0] din1;
   logic       out1, vld1, st1, drop1;

   int   total = 0;
   int   bad   = 0;
   logic exp_q[$];
   logic exp_bit;

   shadow_chain_unload #(.CHAIN_LEN(8), .PARITY(1)) dut (
      .clk(clk), .rst(rst), .capture(capture), .din(din), .dump_cmd(dump_cmd),
      .chain_out(chain_out), .chain_vld(chain_vld), .chain_status(chain_status),
      .capture_drop(capture_drop)
   );

   shadow_chain_unload #(.CHAIN_LEN(1), .PARITY(0)) dut1 (
      .clk(clk), .rst(rst), .capture(capture1), .din(din1), .dump_cmd(dump1),
      .chain_out(out1), .chain_vld(vld1), .chain_status(st1),
      .capture_drop(drop1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, act, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   // Queue nbits data bits of d LSB first; with_par appends the even-parity trailer.
   task automatic push_word(input logic [7:0] d, input int nbits, input bit with_par);
      logic p;
      p = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         exp_q.push_back(d[i]);
         p = p ^ d[i];
      end
      if (with_par) exp_q.push_back(p);
   endtask

   always @(negedge clk) begin
      if (chain_vld === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_bit got=%0b want=none", chain_out);
         end else begin
            exp_bit = exp_q.pop_front();
            if (chain_out !== exp_bit) begin
               bad++;
               $display("FAIL stream_bit got=%0b want=%0b", chain_out, exp_bit);
            end
         end
      end
   end

   initial begin
      rst = 1'b1; capture = 1'b0; dump_cmd = 1'b0; din = '0;
      capture1 = 1'b0; dump1 = 1'b0; din1 = '0;
      next();
      next();
      chk("rst_out", int'(chain_out), 0);
      chk("rst_vld", int'(chain_vld), 0);
      chk("rst_status", int'(chain_status), 1);
      chk("rst_drop", int'(capture_drop), 0);
      chk("rst_status1", int'(st1), 1);
      rst = 1'b0;

      // Plain unload of A5 with continuous grant
      push_word(8'hA5, 8, 1'b1);
      capture = 1'b1; din = 8'hA5;
      next();
      chk("a_loaded_status", int'(chain_status), 0);
      chk("a_loaded_vld", int'(chain_vld), 0);
      capture = 1'b0; dump_cmd = 1'b1;
      for (int i = 0; i < 9; i++) begin
         next();
         chk("a_vld", int'(chain_vld), 1);
      end
      next();
      chk("a_end_vld", int'(chain_vld), 0);
      chk("a_end_status", int'(chain_status), 1);
      dump_cmd = 1'b0;
      chk("a_drain", exp_q.size(), 0);

      // Pause of three cycles after the fourth bit
      push_word(8'hA5, 8, 1'b1);
      capture = 1'b1; din = 8'hA5;
      next();
      capture = 1'b0; dump_cmd = 1'b1;
      for (int i = 0; i < 4; i++) begin
         next();
         chk("b_vld_pre", int'(chain_vld), 1);
      end
      dump_cmd = 1'b0;
      for (int i = 0; i < 3; i++) begin
         next();
         chk("b_gap_vld", int'(chain_vld), 0);
         chk("b_gap_status", int'(chain_status), 0);
         chk("b_gap_hold", int'(chain_out), 0);
      end
      dump_cmd = 1'b1;
      for (int i = 0; i < 5; i++) begin
         next();
         chk("b_vld_post", int'(chain_vld), 1);
      end
      next();
      chk("b_end_vld", int'(chain_vld), 0);
      chk("b_end_status", int'(chain_status), 1);
      dump_cmd = 1'b0;
      chk("b_drain", exp_q.size(), 0);

      // Grant while empty does nothing
      dump_cmd = 1'b1;
      for (int i = 0; i < 20; i++) begin
         next();
         chk("c_vld", int'(chain_vld), 0);
         chk("c_status", int'(chain_status), 1);
      end
      dump_cmd = 1'b0;

      // Capture during shift is dropped
      push_word(8'h0F, 8, 1'b1);
      capture = 1'b1; din = 8'h0F;
      next();
      capture = 1'b0; dump_cmd = 1'b1;
      for (int i = 0; i < 3; i++) begin
         next();
         chk("d_vld", int'(chain_vld), 1);
      end
      capture = 1'b1; din = 8'hFF;
      next();
      chk("d_vld_cap", int'(chain_vld), 1);
      chk("d_drop", int'(capture_drop), 1);
      capture = 1'b0;
      next();
      chk("d_drop_clear", int'(capture_drop), 0);
      chk("d_vld_next", int'(chain_vld), 1);
      for (int i = 0; i < 4; i++) begin
         next();
         chk("d_vld_rest", int'(chain_vld), 1);
      end
      next();
      chk("d_end_vld", int'(chain_vld), 0);
      chk("d_end_status", int'(chain_status), 1);
      dump_cmd = 1'b0;
      chk("d_drain", exp_q.size(), 0);

      // Capture coincident with the final (parity) bit
      push_word(8'hA5, 8, 1'b1);
      capture = 1'b1; din = 8'hA5;
      next();
      capture = 1'b0; dump_cmd = 1'b1;
      for (int i = 0; i < 8; i++) next();
      capture = 1'b1; din = 8'hFF;
      next();
      chk("e_last_vld", int'(chain_vld), 1);
      chk("e_last_drop", int'(capture_drop), 1);
      capture = 1'b0;
      next();
      chk("e_end_vld", int'(chain_vld), 0);
      chk("e_end_status", int'(chain_status), 1);
      chk("e_end_drop", int'(capture_drop), 0);
      dump_cmd = 1'b0;
      chk("e_drain", exp_q.size(), 0);

      // Recapture in LOADED beats a same-cycle grant
      push_word(8'h80, 8, 1'b1);
      capture = 1'b1; din = 8'h01;
      next();
      capture = 1'b1; din = 8'h80; dump_cmd = 1'b1;
      next();
      chk("f_hold_vld", int'(chain_vld), 0);
      chk("f_hold_status", int'(chain_status), 0);
      capture = 1'b0;
      next();
      chk("f_first_vld", int'(chain_vld), 1);
      for (int i = 0; i < 8; i++) begin
         next();
         chk("f_vld", int'(chain_vld), 1);
      end
      next();
      chk("f_end_vld", int'(chain_vld), 0);
      chk("f_end_status", int'(chain_status), 1);
      dump_cmd = 1'b0;
      chk("f_drain", exp_q.size(), 0);

      // Reset at bit 5 discards the rest; rst beats a same-cycle capture
      push_word(8'hA5, 5, 1'b0);
      capture = 1'b1; din = 8'hA5;
      next();
      capture = 1'b0; dump_cmd = 1'b1;
      for (int i = 0; i < 5; i++) next();
      rst = 1'b1; capture = 1'b1; din = 8'hFF;
      next();
      chk("g_rst_out", int'(chain_out), 0);
      chk("g_rst_vld", int'(chain_vld), 0);
      chk("g_rst_status", int'(chain_status), 1);
      chk("g_rst_drop", int'(capture_drop), 0);
      rst = 1'b0; capture = 1'b0;
      for (int i = 0; i < 3; i++) begin
         next();
         chk("g_idle_vld", int'(chain_vld), 0);
         chk("g_idle_status", int'(chain_status), 1);
      end
      chk("g_drain_rst", exp_q.size(), 0);
      push_word(8'h3C, 8, 1'b1);
      capture = 1'b1; din = 8'h3C;
      next();
      capture = 1'b0;
      for (int i = 0; i < 9; i++) begin
         next();
         chk("g_vld", int'(chain_vld), 1);
      end
      next();
      chk("g_end_vld", int'(chain_vld), 0);
      chk("g_end_status", int'(chain_status), 1);
      dump_cmd = 1'b0;
      chk("g_drain", exp_q.size(), 0);

      // Single-bit chain without parity
      capture1 = 1'b1; din1 = 1'b1;
      next();
      chk("h_status", int'(st1), 0);
      capture1 = 1'b0; dump1 = 1'b1;
      next();
      chk("h_vld", int'(vld1), 1);
      chk("h_out", int'(out1), 1);
      next();
      chk("h_end_vld", int'(vld1), 0);
      chk("h_end_status", int'(st1), 1);
      chk("h_drop", int'(drop1), 0);
      dump1 = 1'b0;

      next();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
